// File: rtl/l2_noc1_pkg.sv
// Shared definitions for the L2 NoC1 request encoder: message types,
// flit field positions and the encoder FSM state type.
package l2_noc1_pkg;

  localparam int FLIT_W    = 64;
  localparam int DATA_W    = 64;
  localparam int HDR_FLITS = 3;
  localparam int NOC_ADDR_W = 40;

  // NoC1 request message types
  localparam logic [7:0] MSG_TYPE_STORE_REQ = 8'd2;
  localparam logic [7:0] MSG_TYPE_LOAD_REQ  = 8'd31;

  // Header flit 1 fields
  localparam int DST_CHIPID_MSB = 63;
  localparam int DST_CHIPID_LSB = 50;
  localparam int DST_X_MSB      = 49;
  localparam int DST_X_LSB      = 42;
  localparam int DST_Y_MSB      = 41;
  localparam int DST_Y_LSB      = 34;
  localparam int FBITS_MSB      = 33;
  localparam int FBITS_LSB      = 30;
  localparam int PLEN_MSB       = 29;
  localparam int PLEN_LSB       = 22;
  localparam int TYPE_MSB       = 21;
  localparam int TYPE_LSB       = 14;
  localparam int MSHRID_MSB     = 13;
  localparam int MSHRID_LSB     = 6;

  // Header flit 2 fields
  localparam int ADDR_MSB       = 63;
  localparam int ADDR_LSB       = 24;

  // Header flit 3 fields (source coordinates share the header-1 layout)
  localparam int SRC_CHIPID_MSB = 63;
  localparam int SRC_CHIPID_LSB = 50;
  localparam int SRC_X_MSB      = 49;
  localparam int SRC_X_LSB      = 42;
  localparam int SRC_Y_MSB      = 41;
  localparam int SRC_Y_LSB      = 34;
  localparam int SRC_FBITS_MSB  = 33;
  localparam int SRC_FBITS_LSB  = 30;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR1 = 3'd1,
    ST_HDR2 = 3'd2,
    ST_HDR3 = 3'd3,
    ST_DATA = 3'd4
  } enc_state_e;

endpackage

// File: rtl/l2_noc1_req_encoder_flit_mux.sv
// Combinational NoC1 flit formatter: builds the header or data flit
// selected by i_sel from one set of request fields.
// ADDR_W must not exceed 40; the address is zero-extended to 40 bits.
module l2_noc1_flit_mux
  import l2_noc1_pkg::*;
#(
  parameter int ADDR_W = 40
) (
  input  enc_state_e          i_sel,
  input  logic                i_data_idx,
  input  logic [1:0]          i_data_cnt_eff,
  input  logic [7:0]          i_type,
  input  logic [7:0]          i_mshrid,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [13:0]         i_dst_chipid,
  input  logic [7:0]          i_dst_x,
  input  logic [7:0]          i_dst_y,
  input  logic [13:0]         i_src_chipid,
  input  logic [7:0]          i_src_x,
  input  logic [7:0]          i_src_y,
  input  logic [127:0]        i_data,
  output logic [FLIT_W-1:0]   o_flit
);

  logic [NOC_ADDR_W-1:0] w_addr40;
  logic [7:0]            w_plen;

  // Assemble the selected flit; unused bit fields stay zero.
  always_comb begin
    w_addr40               = '0;
    w_addr40[ADDR_W-1:0]   = i_addr;
    w_plen                 = 8'd2 + {6'd0, i_data_cnt_eff};
    o_flit                 = '0;
    case (i_sel)
      ST_HDR1: begin
        o_flit[DST_CHIPID_MSB:DST_CHIPID_LSB] = i_dst_chipid;
        o_flit[DST_X_MSB:DST_X_LSB]           = i_dst_x;
        o_flit[DST_Y_MSB:DST_Y_LSB]           = i_dst_y;
        o_flit[FBITS_MSB:FBITS_LSB]           = 4'b0000;
        o_flit[PLEN_MSB:PLEN_LSB]             = w_plen;
        o_flit[TYPE_MSB:TYPE_LSB]             = i_type;
        o_flit[MSHRID_MSB:MSHRID_LSB]         = i_mshrid;
      end
      ST_HDR2: begin
        o_flit[ADDR_MSB:ADDR_LSB] = w_addr40;
      end
      ST_HDR3: begin
        o_flit[SRC_CHIPID_MSB:SRC_CHIPID_LSB] = i_src_chipid;
        o_flit[SRC_X_MSB:SRC_X_LSB]           = i_src_x;
        o_flit[SRC_Y_MSB:SRC_Y_LSB]           = i_src_y;
        o_flit[SRC_FBITS_MSB:SRC_FBITS_LSB]   = 4'b0000;
      end
      ST_DATA: begin
        o_flit = i_data_idx ? i_data[127:64] : i_data[63:0];
      end
      default: o_flit = '0;
    endcase
  end

endmodule

// File: rtl/l2_noc1_req_encoder.sv
// L2 NoC1 request encoder: captures one abstract request per handshake
// and serializes it as three header flits plus 0..2 data flits on a
// registered valid/ready link.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// HDR1  | presenting header 1 (destination, length, type, mshrid)
// HDR2  | presenting header 2 (address)
// HDR3  | presenting header 3 (source)
// DATA  | presenting data word r_data_idx
module l2_noc1_req_encoder
  import l2_noc1_pkg::*;
#(
  parameter int ADDR_W   = 40,
  parameter int MAX_DATA = 2,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [7:0]          req_type,
  input  logic [7:0]          req_mshrid,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [13:0]         req_dst_chipid,
  input  logic [7:0]          req_dst_x,
  input  logic [7:0]          req_dst_y,
  input  logic [13:0]         req_src_chipid,
  input  logic [7:0]          req_src_x,
  input  logic [7:0]          req_src_y,
  input  logic [127:0]        req_data,
  input  logic [1:0]          req_data_cnt,
  output logic [63:0]         noc1_data_out,
  output logic                noc1_valid_out,
  input  logic                noc1_ready_out,
  output logic [CNT_W-1:0]    msg_cnt,
  output logic                err_o
);

  enc_state_e          r_state;
  logic [7:0]          r_type;
  logic [7:0]          r_mshrid;
  logic [ADDR_W-1:0]   r_addr;
  logic [13:0]         r_dst_chipid;
  logic [7:0]          r_dst_x;
  logic [7:0]          r_dst_y;
  logic [13:0]         r_src_chipid;
  logic [7:0]          r_src_x;
  logic [7:0]          r_src_y;
  logic [127:0]        r_data;
  logic [1:0]          r_data_cnt_eff;
  logic                r_data_idx;
  logic                r_valid;
  logic [FLIT_W-1:0]   r_flit;
  logic [CNT_W-1:0]    r_msg_cnt;
  logic                r_err;

  enc_state_e          w_state_nxt;
  enc_state_e          w_sel;
  logic                w_valid_nxt;
  logic                w_load;
  logic                w_clear;
  logic                w_done;
  logic                w_idx_nxt;
  logic                w_fire;
  logic                w_in_idle;
  logic                w_capture;
  logic                w_cnt_illegal;
  logic [1:0]          w_req_cnt_eff;
  logic [FLIT_W-1:0]   w_flit;

  // Field set feeding the formatter: live request inputs while idle (so
  // header 1 can be registered on the capture edge), captured copy otherwise.
  logic [7:0]          w_f_type;
  logic [7:0]          w_f_mshrid;
  logic [ADDR_W-1:0]   w_f_addr;
  logic [13:0]         w_f_dst_chipid;
  logic [7:0]          w_f_dst_x;
  logic [7:0]          w_f_dst_y;
  logic [13:0]         w_f_src_chipid;
  logic [7:0]          w_f_src_x;
  logic [7:0]          w_f_src_y;
  logic [127:0]        w_f_data;
  logic [1:0]          w_f_cnt_eff;

  assign w_in_idle      = (r_state == ST_IDLE);
  assign w_fire         = r_valid && noc1_ready_out;
  assign w_capture      = w_in_idle && req_valid;
  assign w_cnt_illegal  = (int'(req_data_cnt) > MAX_DATA);
  assign w_req_cnt_eff  = w_cnt_illegal ? MAX_DATA[1:0] : req_data_cnt;

  assign w_f_type       = w_in_idle ? req_type       : r_type;
  assign w_f_mshrid     = w_in_idle ? req_mshrid     : r_mshrid;
  assign w_f_addr       = w_in_idle ? req_addr       : r_addr;
  assign w_f_dst_chipid = w_in_idle ? req_dst_chipid : r_dst_chipid;
  assign w_f_dst_x      = w_in_idle ? req_dst_x      : r_dst_x;
  assign w_f_dst_y      = w_in_idle ? req_dst_y      : r_dst_y;
  assign w_f_src_chipid = w_in_idle ? req_src_chipid : r_src_chipid;
  assign w_f_src_x      = w_in_idle ? req_src_x      : r_src_x;
  assign w_f_src_y      = w_in_idle ? req_src_y      : r_src_y;
  assign w_f_data       = w_in_idle ? req_data       : r_data;
  assign w_f_cnt_eff    = w_in_idle ? w_req_cnt_eff  : r_data_cnt_eff;

  l2_noc1_flit_mux #(
    .ADDR_W (ADDR_W)
  ) u_flit_mux (
    .i_sel          (w_sel),
    .i_data_idx     (w_idx_nxt),
    .i_data_cnt_eff (w_f_cnt_eff),
    .i_type         (w_f_type),
    .i_mshrid       (w_f_mshrid),
    .i_addr         (w_f_addr),
    .i_dst_chipid   (w_f_dst_chipid),
    .i_dst_x        (w_f_dst_x),
    .i_dst_y        (w_f_dst_y),
    .i_src_chipid   (w_f_src_chipid),
    .i_src_x        (w_f_src_x),
    .i_src_y        (w_f_src_y),
    .i_data         (w_f_data),
    .o_flit         (w_flit)
  );

  // Next state, next flit selection and message-completion detection.
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_load      = 1'b0;
    w_clear     = 1'b0;
    w_done      = 1'b0;
    w_sel       = ST_HDR1;
    w_idx_nxt   = r_data_idx;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_state_nxt = ST_HDR1;
          w_valid_nxt = 1'b1;
          w_load      = 1'b1;
          w_sel       = ST_HDR1;
          w_idx_nxt   = 1'b0;
        end
      end
      ST_HDR1: begin
        if (w_fire) begin
          w_state_nxt = ST_HDR2;
          w_load      = 1'b1;
          w_sel       = ST_HDR2;
        end
      end
      ST_HDR2: begin
        if (w_fire) begin
          w_state_nxt = ST_HDR3;
          w_load      = 1'b1;
          w_sel       = ST_HDR3;
        end
      end
      ST_HDR3: begin
        if (w_fire) begin
          if (r_data_cnt_eff != 2'd0) begin
            w_state_nxt = ST_DATA;
            w_load      = 1'b1;
            w_sel       = ST_DATA;
            w_idx_nxt   = 1'b0;
          end else begin
            w_done = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (w_fire) begin
          if ({1'b0, r_data_idx} == (r_data_cnt_eff - 2'd1)) begin
            w_done = 1'b1;
          end else begin
            w_load    = 1'b1;
            w_sel     = ST_DATA;
            w_idx_nxt = r_data_idx + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
        w_clear     = 1'b1;
      end
    endcase
    if (w_done) begin
      w_state_nxt = ST_IDLE;
      w_valid_nxt = 1'b0;
      w_clear     = 1'b1;
    end
  end

  // FSM state, link output registers and data index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_valid    <= 1'b0;
      r_flit     <= '0;
      r_data_idx <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_valid    <= w_valid_nxt;
      r_data_idx <= w_idx_nxt;
      if (w_load) begin
        r_flit <= w_flit;
      end else if (w_clear) begin
        r_flit <= '0;
      end
    end
  end

  // Request field capture on the request handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_type         <= '0;
      r_mshrid       <= '0;
      r_addr         <= '0;
      r_dst_chipid   <= '0;
      r_dst_x        <= '0;
      r_dst_y        <= '0;
      r_src_chipid   <= '0;
      r_src_x        <= '0;
      r_src_y        <= '0;
      r_data         <= '0;
      r_data_cnt_eff <= '0;
    end else if (w_capture) begin
      r_type         <= req_type;
      r_mshrid       <= req_mshrid;
      r_addr         <= req_addr;
      r_dst_chipid   <= req_dst_chipid;
      r_dst_x        <= req_dst_x;
      r_dst_y        <= req_dst_y;
      r_src_chipid   <= req_src_chipid;
      r_src_x        <= req_src_x;
      r_src_y        <= req_src_y;
      r_data         <= req_data;
      r_data_cnt_eff <= w_req_cnt_eff;
    end
  end

  // Completed-message counter (wraps) and sticky illegal-count flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_msg_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_done) begin
        r_msg_cnt <= r_msg_cnt + CNT_W'(1);
      end
      if (w_capture && w_cnt_illegal) begin
        r_err <= 1'b1;
      end
    end
  end

  assign req_ready      = w_in_idle;
  assign noc1_valid_out = r_valid;
  assign noc1_data_out  = r_flit;
  assign msg_cnt        = r_msg_cnt;
  assign err_o          = r_err;

endmodule

// File: tb/tb_l2_noc1_req_encoder.sv
// Self-checking bench for l2_noc1_req_encoder: directed scenarios plus
// randomized requests compared against a field-arithmetic flit model.
module tb_l2_noc1_req_encoder;
  import l2_noc1_pkg::*;

  localparam int CNT_W = 2;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [7:0]        req_type;
  logic [7:0]        req_mshrid;
  logic [39:0]       req_addr;
  logic [13:0]       req_dst_chipid;
  logic [7:0]        req_dst_x;
  logic [7:0]        req_dst_y;
  logic [13:0]       req_src_chipid;
  logic [7:0]        req_src_x;
  logic [7:0]        req_src_y;
  logic [127:0]      req_data;
  logic [1:0]        req_data_cnt;
  logic [63:0]       noc1_data_out;
  logic              noc1_valid_out;
  logic              noc1_ready_out;
  logic [CNT_W-1:0]  msg_cnt;
  logic              err_o;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;
  bit exp_err  = 1'b0;

  typedef struct {
    logic [7:0]  typ;
    logic [7:0]  mshrid;
    logic [39:0] addr;
    logic [13:0] dchip;
    logic [7:0]  dx;
    logic [7:0]  dy;
    logic [13:0] schip;
    logic [7:0]  sx;
    logic [7:0]  sy;
    logic [63:0] w0;
    logic [63:0] w1;
    logic [1:0]  cnt;
  } req_t;

  l2_noc1_req_encoder #(
    .ADDR_W   (40),
    .MAX_DATA (2),
    .CNT_W    (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_type       (req_type),
    .req_mshrid     (req_mshrid),
    .req_addr       (req_addr),
    .req_dst_chipid (req_dst_chipid),
    .req_dst_x      (req_dst_x),
    .req_dst_y      (req_dst_y),
    .req_src_chipid (req_src_chipid),
    .req_src_x      (req_src_x),
    .req_src_y      (req_src_y),
    .req_data       (req_data),
    .req_data_cnt   (req_data_cnt),
    .noc1_data_out  (noc1_data_out),
    .noc1_valid_out (noc1_valid_out),
    .noc1_ready_out (noc1_ready_out),
    .msg_cnt        (msg_cnt),
    .err_o          (err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  function automatic int model_ndata(req_t r);
    return (r.cnt == 2'd3) ? 2 : int'(r.cnt);
  endfunction

  // Expected flit k of a message, built by weighting each field by its bit position.
  function automatic logic [63:0] model_flit(req_t r, int k);
    logic [63:0] f;
    case (k)
      0: f = (64'(r.dchip) << 50) + (64'(r.dx) << 42) + (64'(r.dy) << 34)
           + (64'(2 + model_ndata(r)) << 22) + (64'(r.typ) << 14) + (64'(r.mshrid) << 6);
      1: f = 64'(r.addr) << 24;
      2: f = (64'(r.schip) << 50) + (64'(r.sx) << 42) + (64'(r.sy) << 34);
      3: f = r.w0;
      default: f = r.w1;
    endcase
    return f;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.typ    = 8'($urandom);
    r.mshrid = 8'($urandom);
    r.addr   = {8'($urandom), 32'($urandom)};
    r.dchip  = 14'($urandom);
    r.dx     = 8'($urandom);
    r.dy     = 8'($urandom);
    r.schip  = 14'($urandom);
    r.sx     = 8'($urandom);
    r.sy     = 8'($urandom);
    r.w0     = {32'($urandom), 32'($urandom)};
    r.w1     = {32'($urandom), 32'($urandom)};
    r.cnt    = 2'($urandom_range(0, 3));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic scramble_inputs();
    req_type       = 8'($urandom);
    req_mshrid     = 8'($urandom);
    req_addr       = {8'($urandom), 32'($urandom)};
    req_dst_chipid = 14'($urandom);
    req_dst_x      = 8'($urandom);
    req_dst_y      = 8'($urandom);
    req_src_chipid = 14'($urandom);
    req_src_x      = 8'($urandom);
    req_src_y      = 8'($urandom);
    req_data       = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
    req_data_cnt   = 2'($urandom);
  endtask

  task automatic drive_req(input req_t r);
    req_type       = r.typ;
    req_mshrid     = r.mshrid;
    req_addr       = r.addr;
    req_dst_chipid = r.dchip;
    req_dst_x      = r.dx;
    req_dst_y      = r.dy;
    req_src_chipid = r.schip;
    req_src_x      = r.sx;
    req_src_y      = r.sy;
    req_data       = {r.w1, r.w0};
    req_data_cnt   = r.cnt;
    req_valid      = 1'b1;
  endtask

  // Called at a falling edge with the encoder idle; returns at the falling
  // edge after completion, so consecutive calls are back-to-back.
  task automatic run_msg(input req_t r, input int stall_at, input int stall_n, input bit rnd);
    int  n;
    int  stalls;
    bit  ok;
    bit  rdy;
    n = HDR_FLITS + model_ndata(r);
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    drive_req(r);
    noc1_ready_out = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    scramble_inputs();
    if (r.cnt == 2'd3) exp_err = 1'b1;
    for (int k = 0; k < n; k++) begin
      ok     = 1'b0;
      stalls = 0;
      for (int cyc = 0; cyc < 40 && !ok; cyc++) begin
        @(negedge clk);
        chk("flit_valid", 64'(noc1_valid_out), 64'd1);
        chk($sformatf("flit%0d_data", k), noc1_data_out, model_flit(r, k));
        chk("req_ready_busy", 64'(req_ready), 64'd0);
        if (k == 0) chk("err_after_capture", 64'(err_o), 64'(exp_err));
        if (k == stall_at && stalls < stall_n) rdy = 1'b0;
        else if (rnd && stalls < 4 && $urandom_range(0, 2) == 0) rdy = 1'b0;
        else rdy = 1'b1;
        if (!rdy) stalls++;
        noc1_ready_out = rdy;
        req_valid      = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk); #1;
        ok = rdy;
      end
      chk("flit_accepted", 64'(ok), 64'd1);
    end
    @(negedge clk);
    req_valid      = 1'b0;
    noc1_ready_out = 1'b0;
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    chk("valid_after_last", 64'(noc1_valid_out), 64'd0);
    chk("req_ready_after_last", 64'(req_ready), 64'd1);
    chk("msg_cnt", 64'(msg_cnt), 64'(exp_cnt));
    chk("err_sticky", 64'(err_o), 64'(exp_err));
  endtask

  initial begin
    req_t r;
    clk            = 1'b0;
    rst_n          = 1'b0;
    req_valid      = 1'b0;
    noc1_ready_out = 1'b0;
    scramble_inputs();
    #22 rst_n = 1'b1;
    @(negedge clk);

    // reset values
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_valid", 64'(noc1_valid_out), 64'd0);
    chk("rst_data", noc1_data_out, 64'd0);
    chk("rst_msg_cnt", 64'(msg_cnt), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);

    // load, single-cycle link
    r = rand_req();
    r.typ = MSG_TYPE_LOAD_REQ; r.mshrid = 8'd5; r.addr = 40'h12_3456_7840; r.cnt = 2'd0;
    run_msg(r, -1, 0, 1'b0);

    // store with 3-cycle backpressure on header 2
    r = rand_req();
    r.typ = MSG_TYPE_STORE_REQ; r.cnt = 2'd1; r.w0 = 64'hDEAD_BEEF_0000_0001;
    run_msg(r, 1, 3, 1'b0);

    // two data words
    r = rand_req();
    r.cnt = 2'd2; r.w0 = 64'h1; r.w1 = 64'h2;
    run_msg(r, -1, 0, 1'b0);

    // illegal count, then a legal request with the error still set
    r = rand_req();
    r.cnt = 2'd3;
    run_msg(r, -1, 0, 1'b0);
    r = rand_req();
    r.cnt = 2'd1;
    run_msg(r, -1, 0, 1'b0);

    // asynchronous reset while header 3 is on the link
    r = rand_req();
    r.cnt = 2'd1;
    drive_req(r);
    noc1_ready_out = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    noc1_ready_out = 1'b0;
    chk("hdr3_before_reset", noc1_data_out, model_flit(r, 2));
    chk("valid_before_reset", 64'(noc1_valid_out), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    exp_err = 1'b0;
    chk("midrst_valid", 64'(noc1_valid_out), 64'd0);
    chk("midrst_data", noc1_data_out, 64'd0);
    chk("midrst_msg_cnt", 64'(msg_cnt), 64'(exp_cnt));
    chk("midrst_err", 64'(err_o), 64'(exp_err));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("req_ready_after_release", 64'(req_ready), 64'd1);

    // counter wrap: five back-to-back header-only requests -> 1,2,3,0,1
    for (int i = 0; i < 5; i++) begin
      r = rand_req();
      r.cnt = 2'd0;
      run_msg(r, -1, 0, 1'b0);
    end

    // randomized requests with random backpressure and stray req_valid
    for (int i = 0; i < 24; i++) begin
      r = rand_req();
      run_msg(r, -1, 0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
